mix_columns_engine: RTL and testbench
=====================================

Name: mix_columns_engine

Overview:
Sequential, parametrised MixColumns engine for the AES datapath. It transforms a full 128-bit AES state in forward (encrypt) or inverse (decrypt) mode. COLS_PER_CYCLE columns are processed per clock, trading area for throughput. Sits between the ShiftRows and AddRoundKey stages, with valid/ready handshakes on both sides.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per cycle; legal values are 1, 2 and 4; any other value is an elaboration error.
OUT_REG, 1, 1 = result held in a registered output buffer; 0 = no extra register stage (see Latency).

Ports:
clk  input  1  Single clock; all state updates on the rising edge.
rst  input  1  Asynchronous, active-high reset.
in_valid  input  1  Input state and mode are valid.
in_ready  output  1  Engine can accept a new state.
in_state  input  128  AES state. Column c occupies bits [127-32c -: 32]. Row 0 is the MSB byte of each column (FIPS-197 order).
in_inv  input  1  0 = forward MixColumns; 1 = InvMixColumns. Sampled at the input handshake.
out_valid  output  1  out_state holds a completed result.
out_ready  input  1  Downstream accepts the result.
out_state  output  128  Transformed state, same byte order as in_state.
busy  output  1  High in the BUSY state.

Behaviour:
- Reset values: in_ready=0 while rst is asserted, then 1 from the first cycle after release. out_valid=0, busy=0, out_state=0. Column counter=0. State=IDLE.
- State machine:
  - IDLE: in_ready=1. On in_valid & in_ready, capture in_state and in_inv into the working register, clear the counter, go to BUSY.
  - BUSY: in_ready=0, busy=1. Each cycle, transform columns [cnt .. cnt+COLS_PER_CYCLE-1] in place and add COLS_PER_CYCLE to cnt. When the last group completes, go to DONE.
  - DONE: out_valid=1, in_ready=0, out_state stable. On out_ready, return to IDLE.
- Latency, handshake to out_valid:
  - OUT_REG=1: 4/COLS_PER_CYCLE + 1 cycles (5, 3 or 2).
  - OUT_REG=0: 4/COLS_PER_CYCLE cycles. out_valid is asserted combinationally in the cycle the final group is written.
- Throughput: one state per 4/COLS_PER_CYCLE + 2 cycles, worst case with OUT_REG=1. No acceptance while a result is pending (single-entry buffer, no overlap).
- Forward column transform: b0=2a0^3a1^a2^a3, with the other rows by cyclic rotation.
  - Implemented as t=a0^a1^a2^a3 and bi = ai ^ t ^ xtime(ai ^ a(i+1 mod 4)).
  - xtime(x) = (x<<1) ^ (x[7] ? 8'h1b : 8'h00).
- Inverse column transform: pre-condition, then apply the forward transform.
  - u = xtime(xtime(a0^a2)), v = xtime(xtime(a1^a3)).
  - a0^=u, a2^=u, a1^=v, a3^=v.
  - Result is identical to multiplying by {0e,0b,0d,09}.
- Mode is latched per state. A change of in_inv mid-operation has no effect.
- in_state and in_inv are ignored when in_ready=0. A held in_valid in DONE is not consumed until the engine returns to IDLE.
- out_ready while out_valid=0 has no effect. Backpressure in DONE is held indefinitely with out_state stable.
- Reset asserted mid-BUSY or in DONE: the pending result is discarded and all outputs return to reset values asynchronously.
- Counter width is 2 bits. Wrap-around from 4 to 0 is the termination condition, not an error.

Decomposition:
- Package aes_pkg:
  - typedefs state_t (logic [127:0]) and col_t (logic [31:0]).
  - function xtime.
  - function get_col / set_col (column c index mapping).
  - constants AES_NB=4 and MIX_POLY=8'h1b.
- Sub-module mix_column_unit: combinational, one column, inputs col and inv, output col.
  - Instantiate COLS_PER_CYCLE copies.
  - A column mux selected by cnt feeds them.

Test Plan:
- Forward, COLS_PER_CYCLE=1: column db135345 -> 8e4da1bc; f20a225c -> 9fdc589d; c6c6c6c6 -> c6c6c6c6; d4d4d4d5 -> d5d5d7d6; 2d26314c -> 4d7ebdf8. out_valid exactly 5 cycles after the handshake.
- FIPS-197 round-1 state d4bf5d30e0b452aeb84111f11e2798e5 -> 046681e5e0cb199a48f8d37a2806264c, for COLS_PER_CYCLE = 1, 2 and 4. Latencies 5, 3 and 2.
- Inverse: 046681e5e0cb199a48f8d37a2806264c with in_inv=1 -> d4bf5d30e0b452aeb84111f11e2798e5. Also: random state, forward then inverse, returns the original.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. out_state stays stable, in_ready=0, and a second in_valid is not accepted until the cycle after out_ready=1.
- Reset mid-BUSY (cycle 2 of 4): out_valid stays 0 and in_ready returns to 1 after release. The next state 8e4da1bc... processes correctly with no stale columns.
- Back-to-back: in_valid held high, out_ready held high, 3 states accepted. Results are in order and the spacing is 4/COLS_PER_CYCLE + 2 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES datapath types and GF(2^8) helpers for the MixColumns engine.
package aes_pkg;

  localparam int unsigned AES_NB   = 4;
  localparam logic [7:0]  MIX_POLY = 8'h1b;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? MIX_POLY : 8'h00);
  endfunction

  // Column c sits at bits [127-32c -: 32]; {~c, 5'h1f} is that top bit index.
  function automatic col_t get_col(input state_t s, input logic [1:0] c);
    return s[{~c, 5'h1f} -: 32];
  endfunction

  function automatic state_t set_col(input state_t s, input logic [1:0] c, input col_t v);
    state_t r;
    r = s;
    r[{~c, 5'h1f} -: 32] = v;
    return r;
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational MixColumns / InvMixColumns on a single 32-bit column.
module mix_column_unit
  import aes_pkg::*;
(
  input  col_t col,
  input  logic inv,
  output col_t res
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] p0, p1, p2, p3;
  logic [7:0] u, v, t;

  always_comb begin
    {a0, a1, a2, a3} = col;
    // Inverse = forward transform applied to a pre-conditioned column.
    u  = xtime(xtime(a0 ^ a2));
    v  = xtime(xtime(a1 ^ a3));
    p0 = inv ? (a0 ^ u) : a0;
    p1 = inv ? (a1 ^ v) : a1;
    p2 = inv ? (a2 ^ u) : a2;
    p3 = inv ? (a3 ^ v) : a3;
    t  = p0 ^ p1 ^ p2 ^ p3;
    res = {p0 ^ t ^ xtime(p0 ^ p1),
           p1 ^ t ^ xtime(p1 ^ p2),
           p2 ^ t ^ xtime(p2 ^ p3),
           p3 ^ t ^ xtime(p3 ^ p0)};
  end

endmodule

// File: rtl/mix_columns_engine.sv
// Sequential MixColumns engine: COLS_PER_CYCLE columns per clock, in-place on a
// working copy of the state, with valid/ready handshakes on both sides.
module mix_columns_engine
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1,
  parameter int unsigned OUT_REG        = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);

  fsm_t       fsm_q, fsm_d;
  logic [1:0] cnt_q, cnt_d;
  state_t     work_q, work_d;
  logic       inv_q, inv_d;
  logic       last;
  state_t     merged;

  col_t   col_sel [COLS_PER_CYCLE];
  col_t   col_res [COLS_PER_CYCLE];
  state_t stage   [COLS_PER_CYCLE+1];

  assign stage[0] = work_q;

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    logic [1:0] idx;
    assign idx        = cnt_q + 2'(g);
    assign col_sel[g] = get_col(work_q, idx);

    mix_column_unit u_mix (
      .col (col_sel[g]),
      .inv (inv_q),
      .res (col_res[g])
    );

    assign stage[g+1] = set_col(stage[g], idx, col_res[g]);
  end

  assign merged = stage[COLS_PER_CYCLE];
  // The 2-bit counter wraps to 0 on the final group; detect it before the wrap.
  assign last   = (32'(cnt_q) + COLS_PER_CYCLE) >= AES_NB;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q  <= IDLE;
      cnt_q  <= '0;
      work_q <= '0;
      inv_q  <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      work_q <= work_d;
      inv_q  <= inv_d;
    end
  end

  always_comb begin
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    work_d = work_q;
    inv_d  = inv_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          work_d = in_state;
          inv_d  = in_inv;
          cnt_d  = '0;
          fsm_d  = BUSY;
        end
      end
      BUSY: begin
        work_d = merged;
        cnt_d  = cnt_q + CNT_STEP;
        if (last) fsm_d = (OUT_REG == 0 && out_ready) ? IDLE : DONE;
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign in_ready = (fsm_q == IDLE) && !rst;
  assign busy     = (fsm_q == BUSY);

  if (OUT_REG != 0) begin : g_oreg
    state_t out_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                          out_q <= '0;
      else if (fsm_q == BUSY && last)   out_q <= merged;
    end

    assign out_valid = (fsm_q == DONE);
    assign out_state = out_q;
  end else begin : g_ocomb
    // Result is presented straight from the datapath during the final group.
    assign out_valid = (fsm_q == DONE) || (fsm_q == BUSY && last);
    assign out_state = (fsm_q == BUSY) ? merged : work_q;
  end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: four configurations driven in lockstep and
// checked against a GF(2^8) matrix-multiply reference model.
module tb_mix_columns_engine;

  localparam int NI = 4;
  localparam int LAT [NI] = '{5, 3, 2, 4};
  localparam int SPC [NI] = '{6, 4, 3, 5};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_inv;
  logic         out_ready;
  logic [127:0] in_state;
  logic         in_ready  [NI];
  logic         out_valid [NI];
  logic         busy      [NI];
  logic [127:0] out_state [NI];

  always #5 clk = ~clk;

  mix_columns_engine #(.COLS_PER_CYCLE(1), .OUT_REG(1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .in_state(in_state),
    .in_inv(in_inv), .out_valid(out_valid[0]), .out_ready(out_ready), .out_state(out_state[0]),
    .busy(busy[0]));
  mix_columns_engine #(.COLS_PER_CYCLE(2), .OUT_REG(1)) u_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .in_state(in_state),
    .in_inv(in_inv), .out_valid(out_valid[1]), .out_ready(out_ready), .out_state(out_state[1]),
    .busy(busy[1]));
  mix_columns_engine #(.COLS_PER_CYCLE(4), .OUT_REG(1)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]), .in_state(in_state),
    .in_inv(in_inv), .out_valid(out_valid[2]), .out_ready(out_ready), .out_state(out_state[2]),
    .busy(busy[2]));
  mix_columns_engine #(.COLS_PER_CYCLE(1), .OUT_REG(0)) u_c1_nreg (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[3]), .in_state(in_state),
    .in_inv(in_inv), .out_valid(out_valid[3]), .out_ready(out_ready), .out_state(out_state[3]),
    .busy(busy[3]));

  int nchk = 0;
  int npass = 0;
  int cyc = 0;
  logic [127:0] exp_cur;
  logic [127:0] expq [NI][$];
  int  hs_t    [NI];
  int  last_hs [NI];
  int  hs_cnt  [NI];
  bit  pend    [NI];
  bit  hold    [NI];
  logic [127:0] prev_out [NI];
  bit  b2b = 1'b0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Circulant matrix product per column: row r uses coefficient m[(k-r) mod 4] for byte k.
  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [7:0] m [4];
    logic [7:0] a [4];
    logic [7:0] acc;
    logic [127:0] r = '0;
    if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = 8'(s >> (120 - 32*c - 8*k));
      for (int rr = 0; rr < 4; rr++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(m[(k - rr + 4) % 4], a[k]);
        r = r | (128'(acc) << (120 - 32*c - 8*rr));
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    nchk++;
    assert (obs === expv) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < NI; i++)
      if (expq[i].size() != 0 || !in_ready[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    for (int i = 0; i < NI; i++) begin
      if (in_valid && in_ready[i]) begin
        expq[i].push_back(exp_cur);
        if (b2b && last_hs[i] >= 0)
          chk($sformatf("spacing[%0d]", i), 128'(cyc - last_hs[i]), 128'(SPC[i]));
        last_hs[i] = cyc;
        hs_t[i]    = cyc;
        hs_cnt[i]++;
        pend[i]    = 1'b1;
      end
      if (out_valid[i]) begin
        if (pend[i]) begin
          chk($sformatf("latency[%0d]", i), 128'(cyc - hs_t[i]), 128'(LAT[i]));
          pend[i] = 1'b0;
        end
        chk($sformatf("in_ready_low[%0d]", i), 128'(in_ready[i]), 128'(0));
        if (hold[i]) chk($sformatf("out_stable[%0d]", i), out_state[i], prev_out[i]);
        if (out_ready) begin
          chk($sformatf("result_pending[%0d]", i), 128'(expq[i].size() != 0), 128'(1));
          if (expq[i].size() != 0) chk($sformatf("result[%0d]", i), out_state[i], expq[i].pop_front());
        end
      end
      hold[i]     = out_valid[i] && !out_ready;
      prev_out[i] = out_state[i];
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int t = 0;
    out_ready = 1'b1;
    while (!all_idle() && t < 40) begin
      tick();
      t++;
    end
    chk("drain_timeout", 128'(t < 40), 128'(1));
    out_ready = 1'b0;
  endtask

  task automatic send(input logic [127:0] s, input logic inv, input logic [127:0] expv);
    in_state = s;
    in_inv   = inv;
    exp_cur  = expv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_inv   = ~inv;
    drain();
  endtask

  task automatic clear_sb();
    for (int i = 0; i < NI; i++) begin
      expq[i].delete();
      pend[i] = 1'b0;
      hold[i] = 1'b0;
      last_hs[i] = -1;
    end
  endtask

  logic [127:0] x, y;
  int base [NI];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b0; in_state = '0; exp_cur = '0;
    for (int i = 0; i < NI; i++) begin hs_cnt[i] = 0; hs_t[i] = 0; end
    clear_sb();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_in_ready[%0d]", i), 128'(in_ready[i]), 128'(0));
      chk($sformatf("rst_out_valid[%0d]", i), 128'(out_valid[i]), 128'(0));
      chk($sformatf("rst_busy[%0d]", i), 128'(busy[i]), 128'(0));
      chk($sformatf("rst_out_state[%0d]", i), out_state[i], 128'(0));
    end
    rst = 1'b0;
    tick();
    for (int i = 0; i < NI; i++) chk($sformatf("post_rst_ready[%0d]", i), 128'(in_ready[i]), 128'(1));

    // Directed column vectors and the FIPS-197 round-1 state.
    send(128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5, 1'b0, 128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6);
    send(128'h2d26314c_db135345_f20a225c_c6c6c6c6, 1'b0, 128'h4d7ebdf8_8e4da1bc_9fdc589d_c6c6c6c6);
    send(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c);
    send(128'h046681e5e0cb199a48f8d37a2806264c, 1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5);

    for (int n = 0; n < 3; n++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      y = model(x, 1'b0);
      send(x, 1'b0, y);
      send(y, 1'b1, x);
    end

    // Backpressure: result held with out_ready low while a second state waits.
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_inv = 1'b0; exp_cur = model(in_state, 1'b0); in_valid = 1'b1;
    tick();
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_inv = 1'b1; exp_cur = model(in_state, 1'b1);
    for (int i = 0; i < NI; i++) base[i] = hs_cnt[i];
    repeat (15) tick();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("bp_valid[%0d]", i), 128'(out_valid[i]), 128'(1));
      chk($sformatf("bp_no_accept[%0d]", i), 128'(hs_cnt[i] - base[i]), 128'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < NI; i++) chk($sformatf("bp_release_no_accept[%0d]", i), 128'(hs_cnt[i] - base[i]), 128'(0));
    tick();
    for (int i = 0; i < NI; i++) chk($sformatf("bp_accept_after[%0d]", i), 128'(hs_cnt[i] - base[i]), 128'(1));
    in_valid = 1'b0;
    drain();

    // Reset during the second BUSY cycle discards the in-flight state.
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_inv = 1'b0; exp_cur = model(in_state, 1'b0); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("mid_rst_out_valid[%0d]", i), 128'(out_valid[i]), 128'(0));
      chk($sformatf("mid_rst_busy[%0d]", i), 128'(busy[i]), 128'(0));
      chk($sformatf("mid_rst_out_state[%0d]", i), out_state[i], 128'(0));
    end
    clear_sb();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    for (int i = 0; i < NI; i++) chk($sformatf("mid_rst_ready[%0d]", i), 128'(in_ready[i]), 128'(1));
    x = 128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6;
    send(x, 1'b0, model(x, 1'b0));

    // Back-to-back with random states and modes changing every cycle.
    clear_sb();
    for (int i = 0; i < NI; i++) base[i] = hs_cnt[i];
    b2b = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      in_state = {$urandom, $urandom, $urandom, $urandom};
      in_inv   = 1'($urandom_range(0, 1));
      exp_cur  = model(in_state, in_inv);
      tick();
    end
    in_valid = 1'b0;
    b2b = 1'b0;
    drain();
    for (int i = 0; i < NI; i++) chk($sformatf("b2b_count[%0d]", i), 128'(hs_cnt[i] - base[i] >= 3), 128'(1));

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
